// File: rtl/util_tx_timestamp_pkg.sv
// Shared types and helpers for the DAC-side timestamp gate: FSM state encoding,
// per-beat timestamp step derivation and saturating statistic increment.
package util_tx_timestamp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DROP   = 3'd4,
        ST_BYPASS = 3'd5
    } ts_state_t;

    // Samples of one enabled channel carried per beat; 0 when the enabled
    // channels do not evenly share the beat (or none are enabled).
    function automatic logic [15:0] ts_step(input logic [15:0] n, input logic [15:0] total);
        logic [15:0] result;
        result = 16'd0;
        if (n != 16'd0) begin
            if ((total % n) == 16'd0) begin
                result = total / n;
            end
        end
        return result;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        logic [31:0] result;
        result = value;
        if (value != max_value) begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/count_bits.sv
// Population count of a bit vector.
module count_bits #(
    parameter int BITS_WIDTH  = 8,
    parameter int COUNT_WIDTH = $clog2(BITS_WIDTH + 1)
) (
    input  logic [BITS_WIDTH-1:0]  in_data,
    output logic [COUNT_WIDTH-1:0] out_count
);

    always_comb begin
        out_count = '0;
        for (int i = 0; i < BITS_WIDTH; i++) begin
            out_count = out_count + COUNT_WIDTH'(in_data[i]);
        end
    end

endmodule

// File: rtl/util_tx_timestamp_gate.sv
// Strips inline timestamp headers and releases each block when the DAC sample
// counter reaches the header time; late/early blocks are dropped or forwarded.
module util_tx_timestamp_gate
    import util_tx_timestamp_pkg::*;
#(
    parameter int NUM_OF_CHANNELS     = 4,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int SAMPLE_DATA_WIDTH   = 16,
    parameter int TIMESTAMP_WIDTH     = 64,
    parameter int STAT_WIDTH          = 16
) (
    input  logic                                                          dac_clk,
    input  logic                                                          resetn,
    input  logic [NUM_OF_CHANNELS-1:0]                                    enable,
    input  logic [TIMESTAMP_WIDTH-1:0]                                    timestamp,
    input  logic [31:0]                                                   block_len,
    input  logic [TIMESTAMP_WIDTH-1:0]                                    early_limit,
    input  logic                                                          late_mode,
    input  logic                                                          s_axis_xfer_req,
    input  logic                                                          s_axis_valid,
    output logic                                                          s_axis_ready,
    input  logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] s_axis_data,
    output logic                                                          m_axis_valid,
    input  logic                                                          m_axis_ready,
    output logic [NUM_OF_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_DATA_WIDTH-1:0] m_axis_data,
    output logic [TIMESTAMP_WIDTH-1:0]                                    m_axis_timestamp,
    output logic                                                          block_start,
    output logic [STAT_WIDTH-1:0]                                         late_count,
    output logic [STAT_WIDTH-1:0]                                         early_count,
    output logic                                                          underflow
);

    // Handshake: a beat transfers on a rising dac_clk edge where valid and ready
    // are both high; valid never waits on ready on either side of the gate.

    localparam int TOTAL_SAMPLES = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL;
    localparam int CNT_W         = $clog2(NUM_OF_CHANNELS + 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    ts_state_t                  state_q, state_d;
    logic [TIMESTAMP_WIDTH-1:0] hdr_ts_q, hdr_ts_d;
    logic [TIMESTAMP_WIDTH-1:0] ts_acc_q, ts_acc_d;
    logic [TIMESTAMP_WIDTH-1:0] step_q, step_d;
    logic [31:0]                len_q, len_d;
    logic [31:0]                beat_q, beat_d;
    logic [STAT_WIDTH-1:0]      late_count_q, late_count_d;
    logic [STAT_WIDTH-1:0]      early_count_q, early_count_d;
    logic                       underflow_q, underflow_d;

    logic [CNT_W-1:0]           n_enabled;
    logic [TIMESTAMP_WIDTH-1:0] step_new;
    logic [TIMESTAMP_WIDTH-1:0] hdr_data;
    logic [TIMESTAMP_WIDTH-1:0] early_bound;
    logic                       is_late;
    logic                       is_early;
    logic                       gate_open;
    logic                       last_beat;
    logic                       fwd_active;

    count_bits #(
        .BITS_WIDTH  (NUM_OF_CHANNELS),
        .COUNT_WIDTH (CNT_W)
    ) u_count_bits (
        .in_data   (enable),
        .out_count (n_enabled)
    );

    assign m_axis_data = s_axis_data;
    assign late_count  = late_count_q;
    assign early_count = early_count_q;
    assign underflow   = underflow_q;

    assign step_new    = TIMESTAMP_WIDTH'(ts_step(16'(n_enabled), 16'(TOTAL_SAMPLES)));
    assign hdr_data    = s_axis_data[TIMESTAMP_WIDTH-1:0];
    assign early_bound = timestamp + early_limit;
    assign is_late     = hdr_data < timestamp;
    assign is_early    = hdr_data > early_bound;
    assign gate_open   = timestamp >= hdr_ts_q;
    // A latched length of 0 ends after a single beat instead of wrapping forever.
    assign last_beat   = ({1'b0, beat_q} + 33'd1) >= {1'b0, len_q};

    always_comb begin
        state_d          = state_q;
        hdr_ts_d         = hdr_ts_q;
        ts_acc_d         = ts_acc_q;
        step_d           = step_q;
        len_d            = len_q;
        beat_d           = beat_q;
        late_count_d     = late_count_q;
        early_count_d    = early_count_q;
        underflow_d      = underflow_q;
        s_axis_ready     = 1'b0;
        m_axis_valid     = 1'b0;
        block_start      = 1'b0;
        m_axis_timestamp = ts_acc_q;
        fwd_active       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_xfer_req) begin
                    state_d = (block_len == 32'd0) ? ST_BYPASS : ST_HEADER;
                end
            end

            ST_HEADER: begin
                s_axis_ready = 1'b1;
                if (s_axis_valid) begin
                    block_start = 1'b1;
                    hdr_ts_d    = hdr_data;
                    ts_acc_d    = hdr_data;
                    len_d       = block_len;
                    beat_d      = 32'd0;
                    step_d      = step_new;
                    if (is_early) begin
                        early_count_d = STAT_WIDTH'(sat_inc(32'(early_count_q), 32'(STAT_MAX)));
                        state_d       = ST_DROP;
                    end else if (is_late) begin
                        late_count_d = STAT_WIDTH'(sat_inc(32'(late_count_q), 32'(STAT_MAX)));
                        state_d      = late_mode ? ST_STREAM : ST_DROP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                m_axis_valid = s_axis_valid && gate_open;
                s_axis_ready = m_axis_ready && gate_open;
                fwd_active   = gate_open;
                if (s_axis_valid && s_axis_ready) begin
                    beat_d   = 32'd1;
                    ts_acc_d = ts_acc_q + step_q;
                    state_d  = last_beat ? ST_HEADER : ST_STREAM;
                end
            end

            ST_STREAM: begin
                m_axis_valid = s_axis_valid;
                s_axis_ready = m_axis_ready;
                fwd_active   = 1'b1;
                if (s_axis_valid && s_axis_ready) begin
                    ts_acc_d = ts_acc_q + step_q;
                    if (last_beat) begin
                        state_d = ST_HEADER;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end

            ST_DROP: begin
                s_axis_ready = 1'b1;
                if (s_axis_valid) begin
                    if (last_beat) begin
                        state_d = ST_HEADER;
                    end else begin
                        beat_d = beat_q + 32'd1;
                    end
                end
            end

            ST_BYPASS: begin
                m_axis_valid     = s_axis_valid;
                s_axis_ready     = m_axis_ready;
                m_axis_timestamp = '0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fwd_active && m_axis_ready && !s_axis_valid) begin
            underflow_d = 1'b1;
        end

        // Transfer end abandons any block and wipes the session statistics.
        if (!s_axis_xfer_req) begin
            state_d       = ST_IDLE;
            hdr_ts_d      = '0;
            ts_acc_d      = '0;
            step_d        = '0;
            len_d         = 32'd0;
            beat_d        = 32'd0;
            late_count_d  = '0;
            early_count_d = '0;
            underflow_d   = 1'b0;
        end
    end

    always_ff @(posedge dac_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            hdr_ts_q      <= '0;
            ts_acc_q      <= '0;
            step_q        <= '0;
            len_q         <= 32'd0;
            beat_q        <= 32'd0;
            late_count_q  <= '0;
            early_count_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_ts_q      <= hdr_ts_d;
            ts_acc_q      <= ts_acc_d;
            step_q        <= step_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            late_count_q  <= late_count_d;
            early_count_q <= early_count_d;
            underflow_q   <= underflow_d;
        end
    end

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Bench for util_tx_timestamp_gate: block-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_util_tx_timestamp_gate;

    localparam int NC    = 4;
    localparam int SPC   = 1;
    localparam int SDW   = 16;
    localparam int TW    = 64;
    localparam int SW    = 16;
    localparam int DW    = NC * SPC * SDW;
    localparam int TOTAL = NC * SPC;

    localparam int ACT_GATE = 0;
    localparam int ACT_PASS = 1;
    localparam int ACT_DROP = 2;

    logic            dac_clk = 1'b0;
    logic            resetn  = 1'b0;
    logic [NC-1:0]   enable;
    logic [TW-1:0]   timestamp;
    logic [31:0]     block_len;
    logic [TW-1:0]   early_limit;
    logic            late_mode;
    logic            s_axis_xfer_req;
    logic            s_axis_valid;
    logic            s_axis_ready;
    logic [DW-1:0]   s_axis_data;
    logic            m_axis_valid;
    logic            m_axis_ready;
    logic [DW-1:0]   m_axis_data;
    logic [TW-1:0]   m_axis_timestamp;
    logic            block_start;
    logic [SW-1:0]   late_count;
    logic [SW-1:0]   early_count;
    logic            underflow;

    always #5 dac_clk = ~dac_clk;

    util_tx_timestamp_gate #(
        .NUM_OF_CHANNELS     (NC),
        .SAMPLES_PER_CHANNEL (SPC),
        .SAMPLE_DATA_WIDTH   (SDW),
        .TIMESTAMP_WIDTH     (TW),
        .STAT_WIDTH          (SW)
    ) dut (
        .dac_clk          (dac_clk),
        .resetn           (resetn),
        .enable           (enable),
        .timestamp        (timestamp),
        .block_len        (block_len),
        .early_limit      (early_limit),
        .late_mode        (late_mode),
        .s_axis_xfer_req  (s_axis_xfer_req),
        .s_axis_valid     (s_axis_valid),
        .s_axis_ready     (s_axis_ready),
        .s_axis_data      (s_axis_data),
        .m_axis_valid     (m_axis_valid),
        .m_axis_ready     (m_axis_ready),
        .m_axis_data      (m_axis_data),
        .m_axis_timestamp (m_axis_timestamp),
        .block_start      (block_start),
        .late_count       (late_count),
        .early_count      (early_count),
        .underflow        (underflow)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record for the block being handled.
    bit          mdl_active   = 0;
    bit          mdl_bypass   = 0;
    bit          mdl_in_block = 0;
    int          mdl_act      = ACT_GATE;
    logic [63:0] mdl_hdr      = '0;
    logic [63:0] mdl_step     = '0;
    logic [63:0] mdl_done     = '0;
    logic [31:0] mdl_len      = '0;
    logic [15:0] mdl_late     = '0;
    logic [15:0] mdl_early    = '0;
    bit          mdl_uf       = 0;

    logic [63:0] obs_mts[$];
    logic [63:0] obs_ts[$];
    int          bs_seen = 0;

    always @(negedge dac_clk) begin : compare_proc
        logic        e_valid;
        logic        e_ready;
        logic        e_bs;
        logic        fwd;
        logic [63:0] e_ts;
        logic [63:0] hdr;
        logic [63:0] need;
        int          n;
        if (!resetn) begin
            mdl_active = 0; mdl_bypass = 0; mdl_in_block = 0;
            mdl_late = '0; mdl_early = '0; mdl_uf = 0;
            check("rst_m_valid", m_axis_valid, 0);
            check("rst_s_ready", s_axis_ready, 0);
            check("rst_block_start", block_start, 0);
            check("rst_underflow", underflow, 0);
            check("rst_late", late_count, 0);
            check("rst_early", early_count, 0);
        end else begin
            e_valid = 0; e_ready = 0; e_bs = 0; fwd = 0; e_ts = '0;
            if (!mdl_active) begin
                e_valid = 0;
            end else if (mdl_bypass) begin
                e_valid = s_axis_valid;
                e_ready = m_axis_ready;
            end else if (!mdl_in_block) begin
                e_ready = 1;
                e_bs    = s_axis_valid;
            end else if (mdl_act == ACT_DROP) begin
                e_ready = 1;
            end else if (mdl_act == ACT_PASS || mdl_done != 0 || timestamp >= mdl_hdr) begin
                fwd     = 1;
                e_valid = s_axis_valid;
                e_ready = m_axis_ready;
                e_ts    = mdl_hdr + mdl_done * mdl_step;
            end

            check("m_valid", m_axis_valid, e_valid);
            check("s_ready", s_axis_ready, e_ready);
            check("block_start", block_start, e_bs);
            check("late_count", late_count, mdl_late);
            check("early_count", early_count, mdl_early);
            check("underflow", underflow, mdl_uf);
            if (e_valid) begin
                check("m_data", m_axis_data, s_axis_data);
                check("m_timestamp", m_axis_timestamp, e_ts);
            end
            if (block_start) bs_seen++;
            if (m_axis_valid && m_axis_ready) begin
                obs_mts.push_back(m_axis_timestamp);
                obs_ts.push_back(timestamp);
            end

            if (!s_axis_xfer_req) begin
                mdl_active = 0; mdl_bypass = 0; mdl_in_block = 0;
                mdl_late = '0; mdl_early = '0; mdl_uf = 0;
            end else begin
                if (fwd && m_axis_ready && !s_axis_valid) mdl_uf = 1;
                if (!mdl_active) begin
                    mdl_active   = 1;
                    mdl_bypass   = (block_len == 0);
                    mdl_in_block = 0;
                end else if (mdl_bypass) begin
                    mdl_bypass = 1;
                end else if (!mdl_in_block) begin
                    if (s_axis_valid) begin
                        hdr      = s_axis_data[TW-1:0];
                        n        = $countones(enable);
                        mdl_hdr  = hdr;
                        mdl_len  = block_len;
                        mdl_step = (n != 0 && (TOTAL % n) == 0) ? 64'(TOTAL / n) : 64'd0;
                        mdl_done = '0;
                        if (hdr > timestamp + early_limit) begin
                            if (mdl_early != 16'hFFFF) mdl_early++;
                            mdl_act = ACT_DROP;
                        end else if (hdr < timestamp) begin
                            if (mdl_late != 16'hFFFF) mdl_late++;
                            mdl_act = late_mode ? ACT_PASS : ACT_DROP;
                        end else begin
                            mdl_act = ACT_GATE;
                        end
                        mdl_in_block = 1;
                    end
                end else if (s_axis_valid && e_ready) begin
                    mdl_done++;
                    need = (mdl_len == 0) ? 64'd1 : 64'(mdl_len);
                    if (mdl_done >= need) mdl_in_block = 0;
                end
            end
        end
    end

    logic [63:0] ts_cnt = '0;

    task automatic tick();
        @(posedge dac_clk);
        #1;
        ts_cnt    = ts_cnt + 64'd1;
        timestamp = ts_cnt;
    endtask

    task automatic set_ts(input logic [63:0] v);
        ts_cnt    = v;
        timestamp = v;
    endtask

    // Holds s_axis_valid high with data d until the DUT accepts it.
    task automatic send_beat(input logic [63:0] d);
        bit ok;
        ok           = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge dac_clk);
            if (s_axis_ready) ok = 1;
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_beat_timeout actual=no_ready required=ready t=%0t", $time);
        end
    endtask

    // Leaves the DUT in the header-expecting state.
    task automatic restart();
        s_axis_valid    = 1'b0;
        s_axis_xfer_req = 1'b0;
        tick();
        s_axis_xfer_req = 1'b1;
        tick();
        obs_mts.delete();
        obs_ts.delete();
        bs_seen = 0;
    endtask

    task automatic send_block(input logic [63:0] hdr, input int beats);
        send_beat(hdr);
        for (int i = 0; i < beats; i++) send_beat({$urandom, $urandom});
        s_axis_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic [63:0] off;
        enable = 4'hF; timestamp = '0; block_len = 32'd4; early_limit = 64'd100;
        late_mode = 1'b0; s_axis_xfer_req = 1'b0; s_axis_valid = 1'b0;
        s_axis_data = '0; m_axis_ready = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        check("reset_m_timestamp", m_axis_timestamp, 0);
        check("reset_state_ready", s_axis_ready, 0);

        // On-time block: released exactly at timestamp 1000.
        restart();
        set_ts(64'd990);
        send_block(64'd1000, 4);
        check("s1_beats", obs_mts.size(), 4);
        check("s1_first_ts_in", obs_ts[0], 1000);
        check("s1_mts0", obs_mts[0], 1000);
        check("s1_mts1", obs_mts[1], 1001);
        check("s1_mts2", obs_mts[2], 1002);
        check("s1_mts3", obs_mts[3], 1003);
        check("s1_block_start", bs_seen, 1);

        // Late block, dropped then forwarded.
        restart();
        set_ts(64'd600);
        send_block(64'd500, 4);
        check("s2_drop_beats", obs_mts.size(), 0);
        check("s2_drop_late", late_count, 1);
        late_mode = 1'b1;
        restart();
        set_ts(64'd600);
        send_block(64'd500, 4);
        check("s2_fwd_beats", obs_mts.size(), 4);
        check("s2_fwd_first_ts_in", obs_ts[0], 601);
        check("s2_fwd_mts3", obs_mts[3], 503);
        check("s2_fwd_late", late_count, 1);

        // Too early, then a block inside the window.
        late_mode = 1'b0;
        restart();
        set_ts(64'd0);
        send_block(64'd200, 4);
        check("s3_early", early_count, 1);
        check("s3_drop_beats", obs_mts.size(), 0);
        send_block(64'd50, 4);
        check("s3_beats", obs_mts.size(), 4);
        check("s3_release_ts", obs_ts[0], 50);
        check("s3_mts0", obs_mts[0], 50);

        // Step from enabled channel count.
        enable = 4'b0101; block_len = 32'd3;
        restart();
        set_ts(64'd0);
        send_block(64'd0, 3);
        check("s4_mts0", obs_mts[0], 0);
        check("s4_mts1", obs_mts[1], 2);
        check("s4_mts2", obs_mts[2], 4);
        obs_mts.delete(); obs_ts.delete();
        enable = 4'b0111;
        set_ts(64'd10);
        send_block(64'd10, 3);
        check("s4_step0_beats", obs_mts.size(), 3);
        check("s4_step0_mts2", obs_mts[2], 10);

        // Underflow, then transfer end clears everything.
        enable = 4'hF; block_len = 32'd8;
        restart();
        set_ts(64'd100);
        send_beat(64'd100);
        send_beat(64'h11);
        send_beat(64'h22);
        s_axis_valid = 1'b0;
        tick();
        tick();
        check("s5_underflow_set", underflow, 1);
        s_axis_xfer_req = 1'b0;
        tick();
        check("s5_underflow_clr", underflow, 0);
        check("s5_idle_ready", s_axis_ready, 0);
        check("s5_late_clr", late_count, 0);

        // Bypass and asynchronous reset mid-block.
        block_len = 32'd0;
        tick();
        s_axis_xfer_req = 1'b1;
        tick();
        s_axis_valid = 1'b1;
        s_axis_data  = 64'hDEAD_BEEF_0123_4567;
        #1;
        check("s6_byp_valid", m_axis_valid, 1);
        check("s6_byp_data", m_axis_data, 64'hDEAD_BEEF_0123_4567);
        check("s6_byp_ts", m_axis_timestamp, 0);
        #1;
        resetn = 1'b0;
        #1;
        check("s6_arst_valid", m_axis_valid, 0);
        check("s6_arst_ready", s_axis_ready, 0);
        check("s6_arst_ts", m_axis_timestamp, 0);
        tick();
        s_axis_valid    = 1'b0;
        s_axis_xfer_req = 1'b0;
        tick();
        resetn = 1'b1;

        // Random traffic, second run near timestamp wrap.
        for (int run = 0; run < 2; run++) begin
            restart();
            set_ts(run == 0 ? 64'd5000 : 64'hFFFF_FFFF_FFFF_FF80);
            for (int c = 0; c < 1500; c++) begin
                if (c % 40 == 0) begin
                    block_len   = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
                    enable      = 4'($urandom_range(0, 15));
                    late_mode   = 1'($urandom_range(0, 1));
                    early_limit = 64'($urandom_range(0, 40));
                end
                s_axis_xfer_req = ($urandom_range(0, 199) != 0);
                s_axis_valid    = ($urandom_range(0, 9) < 8);
                m_axis_ready    = ($urandom_range(0, 9) < 8);
                off             = 64'($urandom_range(0, 80)) - 64'd20;
                s_axis_data     = ts_cnt + off;
                tick();
            end
        end

        s_axis_valid    = 1'b0;
        s_axis_xfer_req = 1'b0;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
